out_signature_capture: RTL and testbench
========================================

Name: out_signature_capture

Overview:
- Response-capture stage directly downstream of the fuzzed DUT top; consumes its 96-bit out_data and 32-bit probe_data every cycle.
- On start, compresses a programmable number of consecutive samples into a 32-bit MISR signature.
- Also counts samples, and counts cycles where out_data changed versus the previous sample.
- The harness compares the signature and counts across simulator builds to expose mismatches without dumping full traces.

Parameters:
- DATA_W, 96, width of out_data_i
- PROBE_W, 32, width of probe_data_i
- SIG_W, 32, signature width
- CNT_W, 16, width of sample and change counters
- POLY, 32'h04C11DB7, MISR feedback polynomial
- SEED, 32'hFFFFFFFF, signature value loaded on start

Ports:
- clkin_data  in  1  sole clock, rising edge
- rstin_data  in  1  synchronous active-high reset
- start_i  in  1  begin capture run; sampled only in IDLE
- num_samples_i  in  CNT_W  samples to capture; latched on accepted start
- out_data_i  in  DATA_W  DUT out_data
- probe_data_i  in  PROBE_W  DUT probe_data
- busy_o  out  1  high in RUN and DONE
- done_o  out  1  single-cycle pulse, run complete
- signature_o  out  SIG_W  current/final MISR value
- sample_cnt_o  out  CNT_W  samples absorbed this run
- change_cnt_o  out  CNT_W  samples differing from predecessor, saturating

Behaviour:
- Reset (rstin_data=1 at edge):
  - state=IDLE
  - busy_o=0, done_o=0
  - signature_o=SEED, sample_cnt_o=0, change_cnt_o=0
  - prev register=0
  - Reset overrides everything, including mid-RUN; the run is abandoned with no done_o.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 with num_samples_i!=0 → RUN next cycle.
    - Latch N=num_samples_i; load signature=SEED; clear both counters.
  - start_i=1 with num_samples_i==0 → DONE next cycle, signature=SEED, counts 0.
  - Otherwise hold all outputs (results of last run stay visible).
- RUN, each cycle:
  - Absorb out_data_i/probe_data_i present at that edge.
  - fold = XOR of DATA_W split into SIG_W slices; zero-pad the top slice if DATA_W is not a multiple of SIG_W.
  - fold ^= probe_data_i, truncated or zero-extended to SIG_W.
  - sig_next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
  - sample_cnt increments by 1.
  - If sample_cnt!=0 and out_data_i!=prev: change_cnt increments, saturating at all-ones.
  - prev<=out_data_i.
  - When the incremented sample_cnt equals N → DONE next cycle.
- DONE:
  - done_o=1 for exactly this one cycle; busy_o still 1.
  - → IDLE next cycle; start_i is ignored in DONE.
- start_i while busy_o=1 is ignored; no queuing.
- Latency:
  - start accepted at edge t; first sample absorbed at edge t+1; last sample at edge t+N.
  - done_o high during cycle t+N+1; final values stable from then until the next accepted start.
- probe_data_i is not part of change detection.
- N=2^CNT_W-1 needs no special handling; sample_cnt never wraps within a run.

Test Plan:
- Reset, then start with N=1, out_data_i=0, probe_data_i=0 → done_o pulses 2 cycles after start; signature_o=32'hFB3EE249, sample_cnt_o=1, change_cnt_o=0.
- Same as above but probe_data_i=32'h00000001 → signature_o=32'hFB3EE248.
- N=4, out_data_i sequence A,A,B,B (A≠B) → sample_cnt_o=4, change_cnt_o=1; busy_o high for exactly 5 cycles.
- Start with num_samples_i=0 → done_o next cycle, signature_o=32'hFFFFFFFF, counts 0, busy_o high 1 cycle.
- start_i asserted every cycle during a N=3 run → exactly one done_o; second run begins only on start seen in IDLE.
- Assert rstin_data in the 2nd RUN cycle of an N=8 run → next cycle IDLE, busy_o=0, signature_o=SEED, counts 0, no done_o.

Source files
------------

// File: rtl/out_signature_capture.sv
// -----------------------------------------------------------------------------
// out_signature_capture
//
// Response-capture stage placed after the fuzzed DUT top. When a start is
// accepted, it compresses a programmable number of consecutive
// (out_data, probe_data) samples into a MISR signature. It also counts the
// samples absorbed and the samples whose out_data differs from the previous
// sample. The harness compares these results between simulator builds, so no
// full trace has to be dumped.
//
// Ports
//   clkin_data     in   1        sole clock, rising edge
//   rstin_data     in   1        synchronous active-high reset
//   start_i        in   1        begin a capture run; only looked at in IDLE
//   num_samples_i  in   CNT_W    samples to capture; latched on accepted start
//   out_data_i     in   DATA_W   DUT out_data
//   probe_data_i   in   PROBE_W  DUT probe_data
//   busy_o         out  1        high in RUN and DONE
//   done_o         out  1        one-cycle pulse when a run completes
//   signature_o    out  SIG_W    current / final MISR value
//   sample_cnt_o   out  CNT_W    samples absorbed in this run
//   change_cnt_o   out  CNT_W    samples that differ from their predecessor
//                                (saturating)
// -----------------------------------------------------------------------------
module out_signature_capture #(
    parameter int               DATA_W  = 96,
    parameter int               PROBE_W = 32,
    parameter int               SIG_W   = 32,
    parameter int               CNT_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED    = 32'hFFFFFFFF
) (
    input  logic               clkin_data,
    input  logic               rstin_data,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   num_samples_i,
    input  logic [DATA_W-1:0]  out_data_i,
    input  logic [PROBE_W-1:0] probe_data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [SIG_W-1:0]   signature_o,
    output logic [CNT_W-1:0]   sample_cnt_o,
    output logic [CNT_W-1:0]   change_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // out_data is split into SIG_W slices. When DATA_W is not a multiple of
    // SIG_W, the top slice is zero-padded.
    localparam int NSLICE = (DATA_W + SIG_W - 1) / SIG_W;
    localparam int PAD_W  = NSLICE * SIG_W;

    // XOR all slices of the data word together, then fold in the probe word
    // (truncated or zero-extended to SIG_W).
    function automatic logic [SIG_W-1:0] fold_sample(
        input logic [DATA_W-1:0]  data,
        input logic [PROBE_W-1:0] probe
    );
        logic [PAD_W-1:0] padded;
        logic [SIG_W-1:0] acc;
        padded = PAD_W'(data);
        acc    = SIG_W'(probe);
        for (int i = 0; i < NSLICE; i++) begin
            acc = acc ^ padded[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    // One MISR step: shift left, feed the polynomial back on MSB, add input.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [SIG_W-1:0] fold
    );
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? POLY : '0;
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ fold;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  n_lat;
    logic [SIG_W-1:0]  sig;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  change_cnt;
    logic [DATA_W-1:0] prev;

    logic [CNT_W-1:0]  cnt_inc;
    logic [SIG_W-1:0]  sig_next;

    always_comb begin
        cnt_inc  = sample_cnt + CNT_W'(1);
        sig_next = misr_step(sig, fold_sample(out_data_i, probe_data_i));
    end

    always_ff @(posedge clkin_data) begin
        if (rstin_data) begin
            state      <= S_IDLE;
            n_lat      <= '0;
            sig        <= SEED;
            sample_cnt <= '0;
            change_cnt <= '0;
            prev       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Without a start, the results of the last run stay
                    // visible.
                    if (start_i) begin
                        n_lat      <= num_samples_i;
                        sig        <= SEED;
                        sample_cnt <= '0;
                        change_cnt <= '0;
                        state      <= (num_samples_i == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    sig        <= sig_next;
                    sample_cnt <= cnt_inc;
                    // The first sample of a run has no predecessor, so it
                    // never counts as a change.
                    if ((sample_cnt != '0) && (out_data_i != prev)) begin
                        change_cnt <= sat_inc(change_cnt);
                    end
                    prev <= out_data_i;
                    if (cnt_inc == n_lat) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy_o       = (state != S_IDLE);
        done_o       = (state == S_DONE);
        signature_o  = sig;
        sample_cnt_o = sample_cnt;
        change_cnt_o = change_cnt;
    end

endmodule

// File: tb/tb_out_signature_capture.sv
// -----------------------------------------------------------------------------
// Testbench for out_signature_capture: scenario tasks drive runs and compare
// the outputs against a behavioural signature / count model.
// -----------------------------------------------------------------------------
module tb_out_signature_capture;

    localparam int          DATA_W  = 96;
    localparam int          PROBE_W = 32;
    localparam int          SIG_W   = 32;
    localparam int          CNT_W   = 16;
    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] SEED    = 32'hFFFFFFFF;

    logic               clkin_data;
    logic               rstin_data;
    logic               start_i;
    logic [CNT_W-1:0]   num_samples_i;
    logic [DATA_W-1:0]  out_data_i;
    logic [PROBE_W-1:0] probe_data_i;
    logic               busy_o;
    logic               done_o;
    logic [SIG_W-1:0]   signature_o;
    logic [CNT_W-1:0]   sample_cnt_o;
    logic [CNT_W-1:0]   change_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0]  q_data[$];
    logic [PROBE_W-1:0] q_probe[$];

    out_signature_capture #(
        .DATA_W (DATA_W),
        .PROBE_W(PROBE_W),
        .SIG_W  (SIG_W),
        .CNT_W  (CNT_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) dut (
        .clkin_data   (clkin_data),
        .rstin_data   (rstin_data),
        .start_i      (start_i),
        .num_samples_i(num_samples_i),
        .out_data_i   (out_data_i),
        .probe_data_i (probe_data_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .signature_o  (signature_o),
        .sample_cnt_o (sample_cnt_o),
        .change_cnt_o (change_cnt_o)
    );

    initial begin
        clkin_data = 1'b0;
        forever #5 clkin_data = ~clkin_data;
    end

    task automatic tick();
        @(posedge clkin_data);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: signature over the first n queued samples.
    function automatic logic [31:0] model_sig(input int n);
        logic [31:0] s;
        logic [31:0] f;
        logic [95:0] d;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            d = q_data[i];
            f = d[31:0] ^ d[63:32] ^ d[95:64] ^ q_probe[i];
            s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
        end
        return s;
    endfunction

    function automatic int model_changes(input int n);
        int c;
        c = 0;
        for (int i = 1; i < n; i++) begin
            if (q_data[i] != q_data[i-1]) c++;
        end
        if (c > 65535) c = 65535;
        return c;
    endfunction

    // Starts a run of n samples, fed from the queues, and observes it over a
    // bounded window. start_i is held high for 'hold' edges, counted from the
    // accepting edge. done_at is the number of edges after acceptance at which
    // done_o was first seen; it stays -1 if done_o never rose.
    task automatic drive_run(
        input  int          n,
        input  int          hold,
        output int          done_at,
        output int          pulses,
        output int          busy_cycles,
        output logic [31:0] sig_d,
        output logic [15:0] sc_d,
        output logic [15:0] cc_d
    );
        done_at     = -1;
        pulses      = 0;
        busy_cycles = 0;
        sig_d       = 'x;
        sc_d        = 'x;
        cc_d        = 'x;
        start_i       = 1'b1;
        num_samples_i = CNT_W'(n);
        tick();
        for (int k = 0; k <= n + 3; k++) begin
            if (busy_o) busy_cycles++;
            if (done_o) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = k;
                    sig_d   = signature_o;
                    sc_d    = sample_cnt_o;
                    cc_d    = change_cnt_o;
                end
            end
            start_i      = (k + 1 < hold);
            out_data_i   = (k < n) ? q_data[k] : rand_data();
            probe_data_i = (k < n) ? q_probe[k] : $urandom();
            tick();
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        start_i       = 1'b1;
        num_samples_i = 16'd5;
        rstin_data    = 1'b1;
        tick();
        tick();
        start_i    = 1'b0;
        rstin_data = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy_o, done_o);
        end
        checks++;
        if (signature_o !== SEED || sample_cnt_o !== 16'd0 || change_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_vals: sig=%h sc=%0d cc=%0d, expected %h 0 0",
                     signature_o, sample_cnt_o, change_cnt_o, SEED);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b after reset release, expected 0", busy_o);
        end
    endtask

    task automatic test_single();
        int da, pl, bc;
        logic [31:0] sg;
        logic [15:0] sc, cc;
        q_data.delete(); q_probe.delete();
        q_data.push_back('0); q_probe.push_back(32'h0);
        drive_run(1, 1, da, pl, bc, sg, sc, cc);
        checks++;
        if (da !== 1 || pl !== 1 || bc !== 2) begin
            errors++;
            $display("FAIL single_timing: done_at=%0d pulses=%0d busy=%0d, expected 1 1 2", da, pl, bc);
        end
        checks++;
        if (sg !== 32'hFB3EE249 || sc !== 16'd1 || cc !== 16'd0) begin
            errors++;
            $display("FAIL single_zero: sig=%h sc=%0d cc=%0d, expected fb3ee249 1 0", sg, sc, cc);
        end
        checks++;
        if (signature_o !== 32'hFB3EE249 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: sig=%h busy=%b, expected fb3ee249 0", signature_o, busy_o);
        end
        q_probe[0] = 32'h00000001;
        drive_run(1, 1, da, pl, bc, sg, sc, cc);
        checks++;
        if (sg !== 32'hFB3EE248 || da !== 1) begin
            errors++;
            $display("FAIL single_probe: sig=%h done_at=%0d, expected fb3ee248 1", sg, da);
        end
    endtask

    task automatic test_changes();
        int da, pl, bc;
        logic [31:0] sg;
        logic [15:0] sc, cc;
        logic [95:0] a, b;
        a = rand_data();
        b = a ^ {64'h0, 32'h00010000};
        q_data.delete(); q_probe.delete();
        q_data.push_back(a); q_data.push_back(a);
        q_data.push_back(b); q_data.push_back(b);
        for (int i = 0; i < 4; i++) q_probe.push_back($urandom());
        drive_run(4, 1, da, pl, bc, sg, sc, cc);
        checks++;
        if (sc !== 16'd4 || cc !== 16'd1) begin
            errors++;
            $display("FAIL changes_cnt: sc=%0d cc=%0d, expected 4 1", sc, cc);
        end
        checks++;
        if (bc !== 5 || da !== 4 || pl !== 1) begin
            errors++;
            $display("FAIL changes_busy: busy=%0d done_at=%0d pulses=%0d, expected 5 4 1", bc, da, pl);
        end
        checks++;
        if (sg !== model_sig(4)) begin
            errors++;
            $display("FAIL changes_sig: sig=%h expected %h", sg, model_sig(4));
        end
    endtask

    task automatic test_zero();
        int da, pl, bc;
        logic [31:0] sg;
        logic [15:0] sc, cc;
        q_data.delete(); q_probe.delete();
        drive_run(0, 1, da, pl, bc, sg, sc, cc);
        checks++;
        if (da !== 0 || bc !== 1 || pl !== 1) begin
            errors++;
            $display("FAIL zero_timing: done_at=%0d busy=%0d pulses=%0d, expected 0 1 1", da, bc, pl);
        end
        checks++;
        if (sg !== SEED || sc !== 16'd0 || cc !== 16'd0) begin
            errors++;
            $display("FAIL zero_vals: sig=%h sc=%0d cc=%0d, expected ffffffff 0 0", sg, sc, cc);
        end
    endtask

    task automatic test_start_spam();
        int da, pl, bc;
        logic [31:0] sg;
        logic [15:0] sc, cc;
        q_data.delete(); q_probe.delete();
        for (int i = 0; i < 3; i++) begin
            q_data.push_back(rand_data());
            q_probe.push_back($urandom());
        end
        // start_i stays high through every RUN and DONE edge and drops in IDLE.
        drive_run(3, 5, da, pl, bc, sg, sc, cc);
        checks++;
        if (pl !== 1 || bc !== 4 || da !== 3) begin
            errors++;
            $display("FAIL spam_once: pulses=%0d busy=%0d done_at=%0d, expected 1 4 3", pl, bc, da);
        end
        checks++;
        if (sg !== model_sig(3) || sc !== 16'd3 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL spam_vals: sig=%h sc=%0d busy=%b, expected %h 3 0", sg, sc, busy_o, model_sig(3));
        end
    endtask

    task automatic test_reset_midrun();
        int pl;
        pl = 0;
        start_i       = 1'b1;
        num_samples_i = 16'd8;
        tick();
        start_i    = 1'b0;
        out_data_i = rand_data();
        tick();
        // Now in the second RUN cycle.
        rstin_data = 1'b1;
        tick();
        rstin_data = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || signature_o !== SEED ||
            sample_cnt_o !== 16'd0 || change_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b sig=%h sc=%0d cc=%0d, expected 0 0 %h 0 0",
                     busy_o, done_o, signature_o, sample_cnt_o, change_cnt_o, SEED);
        end
        for (int k = 0; k < 12; k++) begin
            if (done_o || busy_o) pl++;
            tick();
        end
        checks++;
        if (pl !== 0) begin
            errors++;
            $display("FAIL midrun_quiet: active cycles=%0d after reset, expected 0", pl);
        end
    endtask

    task automatic test_random();
        int da, pl, bc, n;
        logic [31:0] sg, held;
        logic [15:0] sc, cc;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 24);
            q_data.delete(); q_probe.delete();
            for (int i = 0; i < n; i++) begin
                if (i > 0 && ($urandom_range(0, 1) == 0)) q_data.push_back(q_data[i-1]);
                else q_data.push_back(rand_data());
                q_probe.push_back($urandom());
            end
            drive_run(n, 1, da, pl, bc, sg, sc, cc);
            checks++;
            if (sg !== model_sig(n) || sc !== 16'(n) || cc !== 16'(model_changes(n))) begin
                errors++;
                $display("FAIL random_run%0d: n=%0d sig=%h sc=%0d cc=%0d, expected %h %0d %0d",
                         r, n, sg, sc, cc, model_sig(n), n, model_changes(n));
            end
            checks++;
            if (da !== n || bc !== n + 1 || pl !== 1) begin
                errors++;
                $display("FAIL random_timing%0d: done_at=%0d busy=%0d pulses=%0d, expected %0d %0d 1",
                         r, da, bc, pl, n, n + 1);
            end
            for (int k = 0; k < 3; k++) begin
                out_data_i   = rand_data();
                probe_data_i = $urandom();
                tick();
            end
            held = signature_o;
            checks++;
            if (held !== model_sig(n) || sample_cnt_o !== 16'(n)) begin
                errors++;
                $display("FAIL random_hold%0d: sig=%h sc=%0d, expected %h %0d",
                         r, held, sample_cnt_o, model_sig(n), n);
            end
        end
    endtask

    initial begin
        rstin_data    = 1'b0;
        start_i       = 1'b0;
        num_samples_i = '0;
        out_data_i    = '0;
        probe_data_i  = '0;
        test_reset();
        test_single();
        test_changes();
        test_zero();
        test_start_spam();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
